// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with a runtime-programmable pattern,
// selectable overlap mode, input valid qualifier and a saturating match counter.
module seq_detector_param #(
   parameter int                 MAX_LEN         = 8,
   parameter int                 LEN_W           = 4,
   parameter int                 CNT_W           = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
   parameter int                 DEFAULT_LEN     = 4,
   parameter logic               DEFAULT_OVERLAP = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ain,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               count_clr,
   output logic               aout,
   output logic [CNT_W-1:0]   match_count
);

   localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   FILL_MAX  = LEN_W'(MAX_LEN - 1);
   localparam logic [LEN_W-1:0]   DEF_LEN_L = LEN_W'(DEFAULT_LEN);
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [MAX_LEN-1:0] ONES      = {MAX_LEN{1'b1}};

   logic [MAX_LEN-1:0] pat_r;
   logic [LEN_W-1:0]   len_r;
   logic               ovl_r;
   logic [MAX_LEN-2:0] hist_r;
   logic [LEN_W-1:0]   fill_r;
   logic [CNT_W-1:0]   count_r;

   logic [MAX_LEN-1:0] cand_s;
   logic [MAX_LEN-1:0] mask_s;
   logic               fill_ok_s;
   logic               pat_hit_s;
   logic               aout_s;
   logic [LEN_W-1:0]   fill_next_s;

   // A stored length of zero would make the compare window empty, so it is bumped to one.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      if (l == {LEN_W{1'b0}}) begin
         return {{(LEN_W-1){1'b0}}, 1'b1};
      end else if (l > MAX_LEN_L) begin
         return MAX_LEN_L;
      end else begin
         return l;
      end
   endfunction

   // Match decode over the low len bits of history plus the current bit.
   always_comb begin
      cand_s      = {hist_r, ain};
      mask_s      = ONES >> (MAX_LEN_L - len_r);
      fill_ok_s   = ({1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_r};
      pat_hit_s   = ((cand_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}};
      aout_s      = rst & in_valid & ~cfg_load & fill_ok_s & pat_hit_s;
      fill_next_s = fill_r;
      if (aout_s && !ovl_r) begin
         fill_next_s = {LEN_W{1'b0}};
      end else if (fill_r == FILL_MAX) begin
         fill_next_s = FILL_MAX;
      end else begin
         fill_next_s = fill_r + {{(LEN_W-1){1'b0}}, 1'b1};
      end
   end

   // Configuration registers, reloaded only by cfg_load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_r <= DEFAULT_PATTERN;
         len_r <= DEF_LEN_L;
         ovl_r <= DEFAULT_OVERLAP;
      end else if (cfg_load) begin
         pat_r <= cfg_pattern;
         len_r <= clamp_len(cfg_len);
         ovl_r <= cfg_overlap;
      end else begin
         pat_r <= pat_r;
         len_r <= len_r;
         ovl_r <= ovl_r;
      end
   end

   // Bit history and fill level; invalid cycles leave both untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_r <= {(MAX_LEN-1){1'b0}};
         fill_r <= {LEN_W{1'b0}};
      end else if (cfg_load) begin
         hist_r <= {(MAX_LEN-1){1'b0}};
         fill_r <= {LEN_W{1'b0}};
      end else if (in_valid) begin
         hist_r <= cand_s[MAX_LEN-2:0];
         fill_r <= fill_next_s;
      end else begin
         hist_r <= hist_r;
         fill_r <= fill_r;
      end
   end

   // Saturating match counter; clear wins over a coincident match.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (count_clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (aout_s && (count_r != CNT_MAX)) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign aout        = aout_s;
   assign match_count = count_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: an 8-bit-counter instance and a 3-bit-counter
// instance share all inputs so saturation can be observed on the narrow one.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ain = 1'b0;
   logic       in_valid = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = 8'd0;
   logic [3:0] cfg_len = 4'd0;
   logic       cfg_overlap = 1'b0;
   logic       count_clr = 1'b0;
   logic       aout8, aout3;
   logic [7:0] count8;
   logic [2:0] count3;

   int checks = 0;
   int passed = 0;
   int exp8 = 0;
   int exp3 = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .ain(ain), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .count_clr(count_clr), .aout(aout8), .match_count(count8)
   );

   seq_detector_param #(.CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .ain(ain), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .count_clr(count_clr), .aout(aout3), .match_count(count3)
   );

   // Drive one cycle, sample aout mid-cycle, then step past the edge.
   task automatic apply(input logic v, input logic a, output logic o8, output logic o3);
      in_valid = v;
      ain      = a;
      #1;
      o8 = aout8;
      o3 = aout3;
      @(posedge clk);
      #1;
   endtask

   task automatic bump();
      exp8 = exp8 + 1;
      if (exp3 < 7) exp3 = exp3 + 1;
   endtask

   task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      in_valid    = 1'b1;
      ain         = 1'b1;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      ain      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (aout8 !== 1'b0) $display("FAIL reset_aout8: got %0b expected 0", aout8); else passed++;
      checks++; if (aout3 !== 1'b0) $display("FAIL reset_aout3: got %0b expected 0", aout3); else passed++;
      checks++; if (count8 !== 8'd0) $display("FAIL reset_count8: got %0d expected 0", count8); else passed++;
      checks++; if (count3 !== 3'd0) $display("FAIL reset_count3: got %0d expected 0", count3); else passed++;
      in_valid = 1'b0;
      rst      = 1'b1;
   endtask

   task automatic test_default_nonoverlap();
      logic [6:0] bits = 7'b1011011;
      logic [6:0] exp  = 7'b0001000;
      logic o8, o3;
      for (int i = 6; i >= 0; i--) begin
         apply(1'b1, bits[i], o8, o3);
         if (exp[i]) bump();
         checks++; if (o8 !== exp[i]) $display("FAIL dflt_aout8 bit%0d: got %0b expected %0b", 7-i, o8, exp[i]); else passed++;
         checks++; if (o3 !== exp[i]) $display("FAIL dflt_aout3 bit%0d: got %0b expected %0b", 7-i, o3, exp[i]); else passed++;
      end
      checks++; if (count8 !== 8'(exp8)) $display("FAIL dflt_count8: got %0d expected %0d", count8, exp8); else passed++;
   endtask

   task automatic test_overlap();
      logic [6:0] bits_o = 7'b1011011;
      logic [6:0] exp_o  = 7'b0001001;
      logic [7:0] bits_n = 8'b10111011;
      logic [7:0] exp_n  = 8'b00010001;
      logic o8, o3;
      do_cfg(8'b0000_1011, 4'd4, 1'b1);
      for (int i = 6; i >= 0; i--) begin
         apply(1'b1, bits_o[i], o8, o3);
         if (exp_o[i]) bump();
         checks++; if (o8 !== exp_o[i]) $display("FAIL ovl_aout bit%0d: got %0b expected %0b", 7-i, o8, exp_o[i]); else passed++;
      end
      checks++; if (count8 !== 8'(exp8)) $display("FAIL ovl_count8: got %0d expected %0d", count8, exp8); else passed++;
      do_cfg(8'b0000_1011, 4'd4, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         apply(1'b1, bits_n[i], o8, o3);
         if (exp_n[i]) bump();
         checks++; if (o8 !== exp_n[i]) $display("FAIL novl_aout bit%0d: got %0b expected %0b", 8-i, o8, exp_n[i]); else passed++;
      end
      checks++; if (count8 !== 8'(exp8)) $display("FAIL novl_count8: got %0d expected %0d", count8, exp8); else passed++;
   endtask

   task automatic test_gaps();
      logic [8:0] v = 9'b100101001;
      logic [8:0] a = 9'b101011011;
      logic [8:0] e = 9'b000000001;
      logic o8, o3;
      do_cfg(8'b0000_1011, 4'd4, 1'b0);
      for (int i = 8; i >= 0; i--) begin
         apply(v[i], a[i], o8, o3);
         if (e[i]) bump();
         checks++; if (o8 !== e[i]) $display("FAIL gap_aout cyc%0d: got %0b expected %0b", 9-i, o8, e[i]); else passed++;
      end
      checks++; if (count8 !== 8'(exp8)) $display("FAIL gap_count8: got %0d expected %0d", count8, exp8); else passed++;
   endtask

   task automatic test_len_bounds();
      logic [5:0] b3 = 6'b110110;
      logic [5:0] e3 = 6'b001001;
      logic [4:0] b1 = 5'b10110;
      logic [2:0] bo = 3'b101;
      logic [7:0] b8 = 8'b10110011;
      logic [7:0] e8 = 8'b00000001;
      logic o8, o3;
      do_cfg(8'b0000_0110, 4'd3, 1'b0);
      for (int i = 5; i >= 0; i--) begin
         apply(1'b1, b3[i], o8, o3);
         if (e3[i]) bump();
         checks++; if (o8 !== e3[i]) $display("FAIL len3_aout bit%0d: got %0b expected %0b", 6-i, o8, e3[i]); else passed++;
      end
      do_cfg(8'b0000_0001, 4'd0, 1'b0);
      cfg_load = 1'b1;
      in_valid = 1'b1;
      ain      = 1'b1;
      #1;
      checks++; if (aout8 !== 1'b0) $display("FAIL cfgload_discard: got %0b expected 0", aout8); else passed++;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         apply(1'b1, b1[i], o8, o3);
         if (b1[i]) bump();
         checks++; if (o8 !== b1[i]) $display("FAIL len0_aout bit%0d: got %0b expected %0b", 5-i, o8, b1[i]); else passed++;
      end
      do_cfg(8'b0000_0001, 4'd1, 1'b1);
      for (int i = 2; i >= 0; i--) begin
         apply(1'b1, bo[i], o8, o3);
         if (bo[i]) bump();
         checks++; if (o8 !== bo[i]) $display("FAIL len1ovl_aout bit%0d: got %0b expected %0b", 3-i, o8, bo[i]); else passed++;
      end
      do_cfg(8'b1011_0011, 4'd15, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         apply(1'b1, b8[i], o8, o3);
         if (e8[i]) bump();
         checks++; if (o8 !== e8[i]) $display("FAIL lenclamp_aout bit%0d: got %0b expected %0b", 8-i, o8, e8[i]); else passed++;
      end
      checks++; if (count8 !== 8'(exp8)) $display("FAIL len_count8: got %0d expected %0d", count8, exp8); else passed++;
      checks++; if (count3 !== 3'(exp3)) $display("FAIL len_count3: got %0d expected %0d", count3, exp3); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [4:0] b = 5'b11011;
      logic [4:0] e = 5'b00001;
      logic o8, o3;
      do_cfg(8'b0000_0110, 4'd3, 1'b1);
      apply(1'b1, 1'b1, o8, o3);
      apply(1'b1, 1'b0, o8, o3);
      apply(1'b1, 1'b1, o8, o3);
      rst      = 1'b0;
      in_valid = 1'b1;
      ain      = 1'b1;
      #1;
      exp8 = 0;
      exp3 = 0;
      checks++; if (aout8 !== 1'b0) $display("FAIL midrst_aout: got %0b expected 0", aout8); else passed++;
      checks++; if (count8 !== 8'd0) $display("FAIL midrst_count8: got %0d expected 0", count8); else passed++;
      checks++; if (count3 !== 3'd0) $display("FAIL midrst_count3: got %0d expected 0", count3); else passed++;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 4; i >= 0; i--) begin
         apply(1'b1, b[i], o8, o3);
         if (e[i]) bump();
         checks++; if (o8 !== e[i]) $display("FAIL postrst_aout bit%0d: got %0b expected %0b", 5-i, o8, e[i]); else passed++;
      end
      checks++; if (count8 !== 8'(exp8)) $display("FAIL postrst_count8: got %0d expected %0d", count8, exp8); else passed++;
   endtask

   task automatic test_saturation();
      logic o8, o3;
      do_cfg(8'b0000_0001, 4'd1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         apply(1'b1, 1'b1, o8, o3);
         bump();
         checks++; if (o3 !== 1'b1) $display("FAIL sat_aout3 n%0d: got %0b expected 1", i, o3); else passed++;
      end
      checks++; if (count3 !== 3'd7) $display("FAIL sat_count3: got %0d expected 7", count3); else passed++;
      checks++; if (count8 !== 8'(exp8)) $display("FAIL sat_count8: got %0d expected %0d", count8, exp8); else passed++;
      apply(1'b0, 1'b1, o8, o3);
      checks++; if (o8 !== 1'b0) $display("FAIL invalid_aout: got %0b expected 0", o8); else passed++;
      checks++; if (count8 !== 8'(exp8)) $display("FAIL invalid_count8: got %0d expected %0d", count8, exp8); else passed++;
   endtask

   task automatic test_count_clr();
      logic o8, o3;
      count_clr = 1'b1;
      apply(1'b1, 1'b1, o8, o3);
      count_clr = 1'b0;
      exp8 = 0;
      exp3 = 0;
      checks++; if (o8 !== 1'b1) $display("FAIL clr_aout: got %0b expected 1", o8); else passed++;
      checks++; if (count8 !== 8'd0) $display("FAIL clr_count8: got %0d expected 0", count8); else passed++;
      checks++; if (count3 !== 3'd0) $display("FAIL clr_count3: got %0d expected 0", count3); else passed++;
      apply(1'b1, 1'b1, o8, o3);
      bump();
      checks++; if (count8 !== 8'(exp8)) $display("FAIL after_clr_count8: got %0d expected %0d", count8, exp8); else passed++;
      checks++; if (count3 !== 3'(exp3)) $display("FAIL after_clr_count3: got %0d expected %0d", count3, exp3); else passed++;
   endtask

   initial begin
      test_reset();
      test_default_nonoverlap();
      test_overlap();
      test_gaps();
      test_len_bounds();
      test_reset_mid();
      test_saturation();
      test_count_clr();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Mealy serial-pattern detector and successor to the fixed 4-bit "1011" non-overlapping detector. It has the following features:
- Runtime-programmable pattern (1..MAX_LEN bits) and length.
- Selectable overlapping or non-overlapping detection.
- A valid qualifier on the serial input.
- A saturating match counter.

It sits on a serial bit stream in the FSM building-block library. Its reset defaults give the same behaviour as the legacy 1011 non-overlap detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of the length field; must hold MAX_LEN.
- CNT_W, 8, width of the match counter.
- DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset; right-justified, MAX_LEN bits.
- DEFAULT_LEN, 4, length loaded at reset.
- DEFAULT_OVERLAP, 1'b0, overlap mode loaded at reset.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- ain, input, 1, serial data bit.
- in_valid, input, 1, ain is sampled only when high.
- cfg_load, input, 1, loads the cfg_* fields and restarts detection.
- cfg_pattern, input, MAX_LEN, new pattern, right-justified.
- cfg_len, input, LEN_W, new pattern length.
- cfg_overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- count_clr, input, 1, synchronous clear of match_count.
- aout, output, 1, Mealy match pulse, combinational in the cycle of the final pattern bit.
- match_count, output, CNT_W, number of matches, saturating.

Behaviour:
- Reset (rst low, asynchronous):
  - hist=0, fill=0, match_count=0.
  - pat=DEFAULT_PATTERN, len=DEFAULT_LEN, ovl=DEFAULT_OVERLAP.
  - aout=0 while in reset.
- Bit order: pat[len-1] is the first bit received and pat[0] is the last. Legacy 1011 = pattern 4'b1011, len 4.
- State:
  - hist: MAX_LEN-1 bit shift register of past sampled bits, newest in bit 0.
  - fill: count of bits accepted since the last restart, saturating at MAX_LEN-1.
- Candidate: cand = {hist, ain}. The low len bits of cand are compared with the low len bits of pat.
- aout = in_valid & ~cfg_load & (fill >= len-1) & (cand[len-1:0] == pat[len-1:0]).
  - Purely combinational; zero latency from ain.
  - Never asserted when in_valid=0.
- Accepted sample (in_valid=1, cfg_load=0), on the clock edge:
  - hist <= cand[MAX_LEN-2:0].
  - If aout and ovl=0: fill <= 0 (bits of a match cannot be reused).
  - Otherwise: fill <= min(fill+1, MAX_LEN-1).
- in_valid=0: hist and fill hold. Gaps are transparent, so a pattern may span invalid cycles.
- cfg_load=1, on the clock edge:
  - pat<=cfg_pattern, len<=cfg_len, ovl<=cfg_overlap; hist<=0, fill<=0.
  - A simultaneous in_valid sample is discarded and aout=0 that cycle.
  - cfg_len=0 is stored as 1; cfg_len>MAX_LEN is stored as MAX_LEN.
- len=1: aout=1 on every valid ain equal to pat[0], in both modes.
- match_count:
  - Increments on each cycle with aout=1 and saturates at 2^CNT_W-1 (no wrap).
  - count_clr=1 sets it to 0 on the next edge; it takes priority over a coincident match.
  - cfg_load does not clear it.
- Reset mid-pattern: all partial progress is lost. Detection after reset needs a full len bits.

Test Plan:
1. After reset, defaults (1011, non-overlap), in_valid=1, ain=1,0,1,1,0,1,1 -> aout=1 on bit 4 only; match_count=1.
2. cfg_load with pattern 1011, len 4, overlap 1; stream 1,0,1,1,0,1,1 -> aout=1 on bits 4 and 7; match_count=2. Non-overlap with stream 1,0,1,1,1,0,1,1 -> aout on bits 4 and 8.
3. Defaults; stream 1,0,1,1 with in_valid=0 gap cycles between bits (ain toggling in the gaps) -> exactly one aout pulse, on the cycle of the 4th valid bit.
4. cfg_load pattern 3'b110, len 3, non-overlap; stream 1,1,0,1,1,0 -> aout on bits 3 and 6. Then cfg_load with cfg_len=0 and pattern bit0=1 -> every valid 1 pulses aout.
5. Reset asserted after bits 1,0,1 -> aout=0, match_count=0. Following 1 alone does not match; full 1,0,1,1 after release -> one match.
6. CNT_W=3; nine matches -> match_count saturates at 7. count_clr coincident with a match -> match_count=0 next cycle while aout=1 that cycle.
